// File: rtl/tick_monitor_if.sv
// tick_monitor_if: slow clock input, clear and measurement results of a tick monitor
interface tick_monitor_if #(
  parameter int CNT_W = 24
) ();
  logic             slow_clk;
  logic             clear;
  logic             tick;
  logic             fall_tick;
  logic [CNT_W-1:0] period;
  logic             period_valid;
  logic             timeout;
  logic [15:0]      edge_count;
  modport master (
    output slow_clk, clear,
    input  tick, fall_tick, period, period_valid, timeout, edge_count
  );
  modport slave (
    input  slow_clk, clear,
    output tick, fall_tick, period, period_valid, timeout, edge_count
  );
endinterface

// File: rtl/tick_monitor.sv
// tick_monitor: synchronizes a slow clock, flags its edges, measures its period and detects its loss
module tick_monitor #(
  parameter int CNT_W   = 24,
  parameter int TIMEOUT = 12_000_000
) (
  input logic           clock_in,
  input logic           reset,
  tick_monitor_if.slave bus
);
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] MEASURE = 2'd1;
  localparam logic [1:0] LOST    = 2'd2;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] MAX  = '1;
  logic [2:0]       sync_q, sync_d;
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] counter_q, counter_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [15:0]      edge_count_q, edge_count_d;
  logic             tick_q, tick_d;
  logic             fall_tick_q, fall_tick_d;
  logic             period_valid_q, period_valid_d;
  logic             timeout_q, timeout_d;
  logic             rise;
  logic [CNT_W-1:0] count_inc;
  // sync_q = {s3, s2, s1}; clear restarts measurement but leaves the synchronizer running
  always_comb begin
    sync_d         = {sync_q[1:0], bus.slow_clk};
    rise           = ~bus.clear & sync_q[1] & ~sync_q[2];
    count_inc      = counter_q == MAX ? MAX : counter_q + CNT_W'(1);
    tick_d         = rise;
    fall_tick_d    = ~bus.clear & ~sync_q[1] & sync_q[2];
    edge_count_d   = bus.clear ? 16'd0 : edge_count_q + 16'(rise);
    state_d        = state_q;
    counter_d      = counter_q;
    period_d       = period_q;
    period_valid_d = period_valid_q;
    timeout_d      = timeout_q;
    if (bus.clear) begin
      state_d        = IDLE;
      counter_d      = '0;
      period_d       = '0;
      period_valid_d = 1'b0;
      timeout_d      = 1'b0;
    end else if (rise) begin
      state_d   = MEASURE;
      counter_d = '0;
      timeout_d = 1'b0;
      if (state_q == MEASURE) begin
        period_d       = count_inc;
        period_valid_d = 1'b1;
      end
    end else if (state_q == MEASURE) begin
      if (counter_q == LAST) begin
        state_d        = LOST;
        timeout_d      = 1'b1;
        period_valid_d = 1'b0;
      end else begin
        counter_d = count_inc;
      end
    end
  end
  // all state registers, cleared immediately by reset
  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      sync_q         <= '0;
      state_q        <= IDLE;
      counter_q      <= '0;
      period_q       <= '0;
      edge_count_q   <= '0;
      tick_q         <= 1'b0;
      fall_tick_q    <= 1'b0;
      period_valid_q <= 1'b0;
      timeout_q      <= 1'b0;
    end else begin
      sync_q         <= sync_d;
      state_q        <= state_d;
      counter_q      <= counter_d;
      period_q       <= period_d;
      edge_count_q   <= edge_count_d;
      tick_q         <= tick_d;
      fall_tick_q    <= fall_tick_d;
      period_valid_q <= period_valid_d;
      timeout_q      <= timeout_d;
    end
  end
  assign bus.tick         = tick_q;
  assign bus.fall_tick    = fall_tick_q;
  assign bus.period       = period_q;
  assign bus.period_valid = period_valid_q;
  assign bus.timeout      = timeout_q;
  assign bus.edge_count   = edge_count_q;
endmodule

// File: doc/tick_monitor.md
TICK_MONITOR -- requirements
Module: tick_monitor

Interface
REQ-001 SHALL have parameter CNT_W, default 24: width of the period counter and the period output.
REQ-002 SHALL have parameter TIMEOUT, default 12_000_000: clock_in cycles without a slow_clk rising edge before the input is declared lost; legal range 2 to 2^CNT_W-1.
REQ-003 SHALL have port clock_in  input  1  system clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port slow_clk  input  1  divided clock from the divider; asynchronous to clock_in.
REQ-006 SHALL have port clear  input  1  synchronous, active-high restart of measurement.
REQ-007 SHALL have port tick  output  1  one-cycle pulse per slow_clk rising edge.
REQ-008 SHALL have port fall_tick  output  1  one-cycle pulse per slow_clk falling edge.
REQ-009 SHALL have port period  output  CNT_W  last measured rise-to-rise interval, in clock_in cycles.
REQ-010 SHALL have port period_valid  output  1  period holds a complete measurement.
REQ-011 SHALL have port timeout  output  1  slow_clk is declared lost.
REQ-012 SHALL have port edge_count  output  16  count of rising edges detected.

Function
REQ-013 SHALL pass slow_clk through a 2-flop synchronizer (s1, s2) plus a history flop s3; edge detection SHALL use only s2 and s3.
REQ-014 SHALL register tick = s2 & ~s3; if edge k is the first clock_in edge that samples slow_clk high, tick SHALL be high for exactly the cycle after edge k+2.
REQ-015 SHALL register fall_tick = ~s2 & s3, with the same latency as tick.
REQ-016 SHALL implement FSM states IDLE, MEASURE, LOST; the rise event is the registered tick condition.
REQ-017 IDLE: the counter SHALL hold at 0; on a rise, go to MEASURE with counter 0; period SHALL NOT update.
REQ-018 MEASURE: the counter SHALL increment by 1 each cycle, saturating at 2^CNT_W-1.
REQ-019 MEASURE, on a rise: period <= counter+1 (saturating), period_valid <= 1, counter <= 0.
REQ-020 MEASURE, no rise while counter == TIMEOUT-1: go to LOST, timeout <= 1, period_valid <= 0; period SHALL keep its last value.
REQ-021 LOST: the counter SHALL hold; on a rise, go to MEASURE, timeout <= 0, counter <= 0; period_valid SHALL stay 0 until the next full period completes.
REQ-022 A rise in the same cycle as counter == TIMEOUT-1 SHALL take precedence; no timeout occurs.
REQ-023 edge_count SHALL increment on every rise in every state and wrap 0xFFFF -> 0x0000.
REQ-024 clear SHALL, synchronously:
  - return the FSM to IDLE;
  - zero counter, period, edge_count;
  - deassert period_valid, timeout, tick, fall_tick.
REQ-025 clear SHALL override a coincident rise: no tick, no count.
REQ-026 clear SHALL leave s1, s2 and s3 running, so a level already high does not produce a false tick after clear.
REQ-027 tick and fall_tick SHALL never be high in the same cycle; each SHALL be high for at most 1 consecutive cycle.

Reset
REQ-028 Asserting reset SHALL immediately force all flops to 0 and the FSM to IDLE: s1, s2, s3, counter, period, edge_count, tick, fall_tick, period_valid, timeout.
REQ-029 After reset deasserts, the first clock_in edge SHALL begin normal operation; a slow_clk already high SHALL produce one tick, after the REQ-014 latency.
REQ-030 Reset asserted mid-measurement SHALL discard the partial count; period_valid SHALL remain 0 until two rises have been observed after reset.

Verification (TIMEOUT=20, CNT_W=8 unless stated)
REQ-031 slow_clk toggling every 5 clock_in cycles -> tick every 10 cycles; after the 2nd rise, period=10 and period_valid=1; edge_count increments by 1 per tick.
REQ-032 slow_clk held low after 3 rises -> 20 cycles after the last rise: timeout=1, period_valid=0, period still 10; resume toggling -> timeout=0 on the first tick, period_valid=1 on the second.
REQ-033 Rise arrives exactly when the counter reaches 19 -> timeout stays 0, period=20, period_valid=1.
REQ-034 clear pulsed while slow_clk is high and a rise is pending -> no tick; edge_count=0, period=0, state IDLE; the next genuine rise gives tick and no period update.
REQ-035 reset asserted mid-period for 1 cycle -> all outputs 0 immediately; a 16-bit edge_count preset near 0xFFFF by 2 extra rises wraps to 0x0001.
REQ-036 CNT_W=4, TIMEOUT=15, slow_clk period 14 -> period=14; a period exceeding 15 -> timeout asserted and period not updated.
